fifo_rd_framer: RTL and testbench
=================================

FIFO_RD_FRAMER -- requirements
Module: fifo_rd_framer

Interface
REQ-001 Parameter DSIZE, default 8: data word width in bits; matches the FIFO data width.
REQ-002 Parameter PKT_LEN, default 4: data words per packet; legal range 1..255.
REQ-003 rclk  input  1  single clock; all state updates on rising edge.
REQ-004 rrst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  permits a new packet to start; sampled only in IDLE.
REQ-006 rempty  input  1  FIFO read-side empty flag.
REQ-007 rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (first-word fall-through).
REQ-008 rinc  output  1  FIFO pop strobe, combinational.
REQ-009 out_data  output  DSIZE  stream data, registered.
REQ-010 out_valid  output  1  stream valid, registered.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_last  output  1  marks the checksum beat, registered.
REQ-013 pkt_count  output  16  count of completed packets, registered.

Function
REQ-014 Internal signal can_load SHALL equal (!out_valid || out_ready).
REQ-015 A stream transfer SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-016 rinc SHALL be 1 only when can_load=1, rempty=0, and either state=DATA, or state=IDLE with en=1.
REQ-017 rinc SHALL never be 1 while rempty=1, in CSUM, or while rrst=1.
REQ-018 On an edge with rinc=1: out_data<=rdata, out_valid<=1, out_last<=0, sum<=sum+rdata mod 2^DSIZE, word_cnt<=word_cnt+1.
REQ-019 IDLE->DATA on a pop (IDLE->CSUM if PKT_LEN=1); DATA->CSUM on the pop where word_cnt reaches PKT_LEN.
REQ-020 In CSUM with can_load=1: out_data<=sum, out_valid<=1, out_last<=1, sum<=0, word_cnt<=0, next state IDLE.
REQ-021 On an edge with can_load=1 and no load, out_valid SHALL go to 0.
REQ-022 When out_valid=1 and out_ready=0: out_data, out_valid and out_last SHALL hold unchanged.
REQ-023 Load latency SHALL be 1 cycle, pop edge to out_valid=1.
REQ-024 With rempty=0 and out_ready=1 held, throughput SHALL be PKT_LEN+1 beats in PKT_LEN+1 consecutive cycles.
REQ-025 rempty=1 mid-packet SHALL stall DATA with sum and word_cnt held and no data lost; the packet resumes when rempty falls.
REQ-026 en=0 SHALL not abort a packet in progress.
REQ-027 pkt_count SHALL increment by 1, wrapping at 2^16, on each transfer with out_last=1.

Reset
REQ-028 Edges with rrst=1 SHALL set state=IDLE, word_cnt=0, sum=0, out_data=0, out_valid=0, out_last=0, pkt_count=0.
REQ-029 Reset mid-packet SHALL discard the partial packet; popped words are not replayed, and the first packet after reset starts clean.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the state enum (IDLE, DATA, CSUM) and the default DSIZE constant.
REQ-031 Single module; no sub-module is warranted; word_cnt width SHALL be 8 bits.

Verification (DSIZE=8, PKT_LEN=4)
REQ-032 FIFO holds 01,02,03,04; out_ready=1; en=1 -> out 01,02,03,04,0A on 5 consecutive cycles, out_last on 0A only, pkt_count=1.
REQ-033 Words FF,FF,02,01 -> checksum beat 01 (mod-256 wrap).
REQ-034 out_ready=0 for 3 cycles while 02 is presented -> 02 held stable, rinc=0 for those cycles, no loss or duplication.
REQ-035 rempty=1 for 5 cycles after the 2nd word -> stall; checksum is still correct when the packet completes; rinc never 1 while rempty=1.
REQ-036 en=0 in IDLE with FIFO non-empty -> rinc=0 and out_valid=0; en=0 asserted mid-packet -> the current packet completes.
REQ-037 rrst=1 for 1 cycle after the 2nd word -> outputs return to reset values; the next packet's checksum covers only the new words.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side packet framer: FSM states and the
// default data width.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam int DSIZE_DEF = 8;

endpackage

// File: rtl/fifo_rd_framer.sv
// Pops PKT_LEN words from a first-word-fall-through FIFO, streams them out, and
// appends a mod-2^DSIZE checksum beat flagged with out_last.
module fifo_rd_framer
    import fifo_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int PKT_LEN = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      pkt_count
);

    state_t           state_q, state_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic [DSIZE-1:0] sum_q, sum_d;
    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic can_load;
    logic last_word;

    assign can_load  = !out_valid_q || out_ready;
    assign last_word = (word_cnt_q == 8'(PKT_LEN - 1));

    // The pop strobe is masked by reset so no word is lost while the block is held.
    assign rinc = !rrst && can_load && !rempty &&
                  ((state_q == DATA) || ((state_q == IDLE) && en));

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        sum_d       = sum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pkt_count_d = pkt_count_q;

        if (out_valid_q && out_ready && out_last_q)
            pkt_count_d = pkt_count_q + 16'd1;

        if (rinc) begin
            out_data_d  = rdata;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            sum_d       = sum_q + rdata;
            word_cnt_d  = word_cnt_q + 8'd1;
            state_d     = last_word ? CSUM : DATA;
        end else if ((state_q == CSUM) && can_load) begin
            out_data_d  = sum_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            sum_d       = '0;
            word_cnt_d  = '0;
            state_d     = IDLE;
        end else if (can_load) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            sum_q       <= sum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Directed bench for fifo_rd_framer with a behavioural FWFT FIFO and a beat
// capture queue; DSIZE=8, PKT_LEN=4.
module tb_fifo_rd_framer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        en;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    bit         force_empty = 1'b0;
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    bit         rinc_seen;

    fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pkt_count (pkt_count)
    );

    always #5 rclk = ~rclk;

    task automatic drive_fifo();
        rempty = force_empty || (fifo.size() == 0);
        rdata  = force_empty ? 8'hAA : ((fifo.size() == 0) ? 8'h00 : fifo[0]);
    endtask

    // One clock: sample pre-edge state, advance, then apply the pop and record any transfer.
    task automatic tick();
        bit         pop, xf, xl;
        logic [7:0] xd, tmp;
        drive_fifo();
        #1;
        pop = rinc; xf = out_valid && out_ready; xd = out_data; xl = out_last;
        rinc_seen = rinc;
        checks++;
        if (rinc && (rempty || rrst)) begin
            errors++;
            $display("FAIL rinc_guard: rinc=%0b rempty=%0b rrst=%0b", rinc, rempty, rrst);
        end
        @(posedge rclk);
        #1;
        if (pop && fifo.size() > 0) tmp = fifo.pop_front();
        if (xf) begin cap_d.push_back(xd); cap_l.push_back(xl); end
        drive_fifo();
    endtask

    task automatic run_until(input int n);
        int budget = 40;
        while (cap_d.size() < n && budget > 0) begin tick(); budget--; end
        checks++;
        if (cap_d.size() < n) begin
            errors++;
            $display("FAIL timeout: beats=%0d need=%0d", cap_d.size(), n);
        end
    endtask

    task automatic test_reset();
        fifo = '{8'h11, 8'h22}; en = 1'b1; out_ready = 1'b1; rrst = 1'b1;
        tick(); tick();
        checks++;
        if (rinc_seen !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %0b want 0", rinc_seen); end
        checks++;
        if ({out_valid, out_last, out_data, pkt_count} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b last=%0b data=%h cnt=%0d want all 0",
                     out_valid, out_last, out_data, pkt_count);
        end
        checks++;
        if (fifo.size() !== 2) begin errors++; $display("FAIL reset_nopop: fifo=%0d want 2", fifo.size()); end
        fifo.delete();
        rrst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        fifo = '{8'h01, 8'h02, 8'h03, 8'h04}; en = 1'b1; out_ready = 1'b1;
        cap_d.delete(); cap_l.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 4)) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%0b data=%h last=%0b want 1 %h %0b",
                         i, out_valid, out_data, out_last, exp_d[i], i == 4);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_end: valid=%0b cnt=%0d want 0 1", out_valid, pkt_count);
        end
    endtask

    task automatic test_wrap();
        fifo = '{8'hFF, 8'hFF, 8'h02, 8'h01};
        cap_d.delete(); cap_l.delete();
        run_until(5);
        checks++;
        if (cap_d.size() != 5 || cap_d[4] !== 8'h01 || cap_l[4] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_csum: beats=%0d csum=%h want 5 01", cap_d.size(),
                     (cap_d.size() == 5) ? cap_d[4] : 8'hXX);
        end
        tick();
        checks++;
        if (pkt_count !== 16'd2) begin errors++; $display("FAIL wrap_cnt: got %0d want 2", pkt_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        fifo = '{8'h01, 8'h02, 8'h03, 8'h04};
        cap_d.delete(); cap_l.delete();
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_data !== 8'h02 || out_valid !== 1'b1 || out_last !== 1'b0 || rinc_seen !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: data=%h valid=%0b last=%0b rinc=%0b want 02 1 0 0",
                         i, out_data, out_valid, out_last, rinc_seen);
            end
        end
        out_ready = 1'b1;
        run_until(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap_d.size() || cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h want %h", i, (i < cap_d.size()) ? cap_d[i] : 8'hXX, exp_d[i]);
            end
        end
        checks++;
        if (cap_d.size() != 5) begin errors++; $display("FAIL bp_count: beats=%0d want 5", cap_d.size()); end
        tick();
    endtask

    task automatic test_stall();
        logic [7:0] exp_d[5] = '{8'h05, 8'h07, 8'h09, 8'h0B, 8'h20};
        fifo = '{8'h05, 8'h07, 8'h09, 8'h0B};
        cap_d.delete(); cap_l.delete();
        tick(); tick();
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || fifo.size() !== 2) begin
            errors++;
            $display("FAIL stall_idle: valid=%0b fifo=%0d want 0 2", out_valid, fifo.size());
        end
        force_empty = 1'b0;
        run_until(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap_d.size() || cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h want %h", i, (i < cap_d.size()) ? cap_d[i] : 8'hXX, exp_d[i]);
            end
        end
        tick();
        checks++;
        if (pkt_count !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", pkt_count); end
    endtask

    task automatic test_enable();
        logic [7:0] exp_d[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        en = 1'b0;
        fifo = '{8'h10, 8'h20, 8'h30, 8'h40};
        cap_d.delete(); cap_l.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rinc_seen !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_idle%0d: rinc=%0b valid=%0b want 0 0", i, rinc_seen, out_valid);
            end
        end
        en = 1'b1;
        tick(); tick();
        en = 1'b0;
        run_until(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap_d.size() || cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL en_beat%0d: got %h want %h", i, (i < cap_d.size()) ? cap_d[i] : 8'hXX, exp_d[i]);
            end
        end
        tick();
        checks++;
        if (pkt_count !== 16'd5) begin errors++; $display("FAIL en_cnt: got %0d want 5", pkt_count); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d[5] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
        fifo = '{8'h01, 8'h02, 8'h03, 8'h04};
        tick(); tick();
        rrst = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_last, out_data, pkt_count} !== 26'd0 || fifo.size() !== 2) begin
            errors++;
            $display("FAIL rstmid_state: valid=%0b last=%0b data=%h cnt=%0d fifo=%0d want 0 0 00 0 2",
                     out_valid, out_last, out_data, pkt_count, fifo.size());
        end
        rrst = 1'b0;
        fifo = '{8'h05, 8'h06, 8'h07, 8'h08};
        cap_d.delete(); cap_l.delete();
        run_until(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap_d.size() || cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h want %h", i, (i < cap_d.size()) ? cap_d[i] : 8'hXX, exp_d[i]);
            end
        end
        tick();
        checks++;
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL rstmid_cnt: got %0d want 1", pkt_count); end
    endtask

    initial begin
        rrst = 1'b1; en = 1'b0; out_ready = 1'b1; rempty = 1'b1; rdata = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_stall();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
